// File: rtl/rv32i_mem_port.sv
// Load/store port between the rv32i datapath and a variable-latency data memory.
// Builds byte enables and lane-replicated store data, and extends load data. Stalls the core until the memory acks or the access times out.
module rv32i_mem_port #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_f3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [TO_W-1:0] cnt;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;
    logic            is_byte, is_half, is_word, bad;
    logic            accept, timeout;
    logic [3:0]      be_nx;
    logic [31:0]     wdata_nx, rdata_ext;
    logic [7:0]      rd_b;
    logic [15:0]     rd_h;

    always_comb begin
        is_byte = (core_f3[1:0] == 2'b00);
        is_half = (core_f3[1:0] == 2'b01);
        is_word = (core_f3 == 3'b010);
        bad     = (core_f3 == 3'b011) || (core_f3 == 3'b110) || (core_f3 == 3'b111) ||
                  (is_half && core_addr[0]) || (is_word && (core_addr[1:0] != 2'b00));
        stall   = core_req && !bad && (state != DONE) && !rst;
    end

    // Loads always fetch the full word; lane selection happens on the way back.
    always_comb begin
        be_nx    = 4'b1111;
        wdata_nx = core_wdata;
        if (core_we && is_byte) begin
            be_nx    = 4'b0001 << core_addr[1:0];
            wdata_nx = {4{core_wdata[7:0]}};
        end else if (core_we && is_half) begin
            be_nx    = core_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nx = {2{core_wdata[15:0]}};
        end
    end

    always_comb begin
        rd_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lane_q)
            2'd0:    rd_b = mem_rdata[7:0];
            2'd1:    rd_b = mem_rdata[15:8];
            2'd2:    rd_b = mem_rdata[23:16];
            default: rd_b = mem_rdata[31:24];
        endcase
        case (f3_q)
            3'b000:  rdata_ext = {{24{rd_b[7]}}, rd_b};
            3'b100:  rdata_ext = {24'd0, rd_b};
            3'b001:  rdata_ext = {{16{rd_h[15]}}, rd_h};
            3'b101:  rdata_ext = {16'd0, rd_h};
            default: rdata_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: if (core_req && !bad) begin
                accept   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (mem_ack) begin
                state_nx = DONE;
            end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                timeout  = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= (state == IDLE) && core_req && bad;
            if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= core_we;
                mem_be    <= be_nx;
                mem_addr  <= {core_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata_nx;
                f3_q      <= core_f3;
                lane_q    <= core_addr[1:0];
                cnt       <= '0;
            end
            if (state == WAIT) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (!mem_we)
                        core_rdata <= rdata_ext;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (timeout) begin
                        mem_req    <= 1'b0;
                        core_rdata <= '0;
                        err        <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32i_mem_port.sv
// Bench for rv32i_mem_port: directed vectors plus random loads/stores against a word-level model.
// A second instance with a short timeout covers abort and reset-in-flight behaviour.
module tb_rv32i_mem_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_req_to;
    logic [2:0]  core_f3;
    logic [15:0] core_addr;
    logic [31:0] core_wdata, mem_rdata;
    logic        mem_ack, ack_to;

    logic [31:0] core_rdata, mem_wdata, core_rdata_to, mem_wdata_to;
    logic        stall, err, mem_req, mem_we, stall_to, err_to, mem_req_to, mem_we_to;
    logic [3:0]  mem_be, mem_be_to;
    logic [15:0] mem_addr, mem_addr_to;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] model_rdata = 0;

    always #5 clk = ~clk;

    rv32i_mem_port #(.ADDR_W(16), .TIMEOUT(255), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we), .core_f3(core_f3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .stall(stall), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

    rv32i_mem_port #(.ADDR_W(16), .TIMEOUT(4), .TO_W(3)) dut_to (
        .clk(clk), .rst(rst), .core_req(core_req_to), .core_we(core_we), .core_f3(core_f3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata_to),
        .stall(stall_to), .err(err_to), .mem_req(mem_req_to), .mem_we(mem_we_to), .mem_be(mem_be_to),
        .mem_addr(mem_addr_to), .mem_wdata(mem_wdata_to), .mem_rdata(mem_rdata), .mem_ack(ack_to));

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_bad(input logic [2:0] f3, input logic [15:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [15:0] a);
        int n;
        if (!we) return 4'hF;
        n = size_of(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] w);
        int n;
        logic [31:0] v, mask;
        n = size_of(f3);
        v = w >> (8 * (a % 4));
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 1;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [15:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int dly,
                          output logic [31:0] got_rd, output logic [3:0] got_be,
                          output logic [31:0] got_wd, output int got_stalls);
        logic [31:0] exp;
        int k;
        bit done, seen;
        k = 0; done = 0; seen = 0; got_stalls = 0; got_be = 'x; got_wd = 'x;
        @(posedge clk); #1;
        core_req = 1; core_we = we; core_f3 = f3; core_addr = a; core_wdata = wd;
        mem_rdata = rd; mem_ack = 0;
        exp = we ? model_rdata : model_load(f3, a, rd);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!stall) done = 1;
            else begin
                got_stalls++;
                if (mem_req) begin
                    if (!seen) begin
                        seen = 1; got_be = mem_be; got_wd = mem_wdata;
                        n_total += 3;
                        if (mem_addr !== (a & 16'hFFFC)) begin n_bad++; $display("FAIL txn_addr: got %h want %h", mem_addr, a & 16'hFFFC); end
                        if (mem_be !== model_be(we, f3, a)) begin n_bad++; $display("FAIL txn_be: got %b want %b", mem_be, model_be(we, f3, a)); end
                        if (mem_we !== we) begin n_bad++; $display("FAIL txn_we: got %b want %b", mem_we, we); end
                        if (we) begin
                            n_total++;
                            if (mem_wdata !== model_wd(f3, wd)) begin n_bad++; $display("FAIL txn_wdata: got %h want %h", mem_wdata, model_wd(f3, wd)); end
                        end
                    end
                    mem_ack = (k == dly);
                    k++;
                end
            end
        end
        n_total += 4;
        if (!done) begin n_bad++; $display("FAIL txn_done: stall never dropped"); end
        if (got_stalls != 2 + dly) begin n_bad++; $display("FAIL txn_stalls: got %0d want %0d", got_stalls, 2 + dly); end
        if (core_rdata !== exp) begin n_bad++; $display("FAIL txn_rdata: got %h want %h", core_rdata, exp); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL txn_err: got %b want 0", err); end
        model_rdata = exp;
        got_rd = core_rdata;
        core_req = 0; mem_ack = 0;
    endtask

    task automatic do_bad(input logic we, input logic [2:0] f3, input logic [15:0] a);
        @(posedge clk); #1;
        core_req = 1; core_we = we; core_f3 = f3; core_addr = a; mem_ack = 0;
        @(negedge clk);
        n_total += 2;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL bad_stall: got %b want 0", stall); end
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL bad_req0: got %b want 0", mem_req); end
        @(posedge clk); #1;
        core_req = 0;
        @(negedge clk);
        n_total += 3;
        if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err: got %b want 1", err); end
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL bad_req1: got %b want 0", mem_req); end
        if (core_rdata !== model_rdata) begin n_bad++; $display("FAIL bad_rdata: got %h want %h", core_rdata, model_rdata); end
        @(negedge clk);
        n_total++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL bad_err_pulse: got %b want 0", err); end
    endtask

    // Load on the short-timeout instance; dly < 0 means the memory never acks.
    task automatic to_txn(input logic [15:0] a, input logic [31:0] rd, input int dly,
                          output int req_cycles, output logic err_seen, output bit done);
        int k;
        k = 0; req_cycles = 0; done = 0; err_seen = 0;
        @(posedge clk); #1;
        core_req_to = 1; core_we = 0; core_f3 = 3'b010; core_addr = a; mem_rdata = rd; ack_to = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (!stall_to) begin done = 1; err_seen = err_to; end
            else if (mem_req_to) begin
                req_cycles++;
                ack_to = (k == dly);
                k++;
            end
        end
        core_req_to = 0; ack_to = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; core_req = 1; core_we = 0; core_f3 = 3'b010; core_addr = 16'h0010;
        core_wdata = 0; mem_rdata = 0; mem_ack = 1; core_req_to = 0; ack_to = 0;
        repeat (2) @(negedge clk);
        n_total += 9;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
        if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
        if (mem_be !== 4'h0) begin n_bad++; $display("FAIL rst_be: got %b want 0", mem_be); end
        if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        if (core_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", core_rdata); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        if (mem_req_to !== 1'b0) begin n_bad++; $display("FAIL rst_req_to: got %b want 0", mem_req_to); end
        core_req = 0; mem_ack = 0;
        @(posedge clk); #1;
        rst = 0;
        model_rdata = 0;
    endtask

    task automatic test_loads();
        logic [31:0] r, w; logic [3:0] b; int s;
        do_txn(0, 3'b010, 16'h0010, 0, 32'hDEADBEEF, 0, r, b, w, s);
        n_total += 3;
        if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", r); end
        if (b !== 4'hF) begin n_bad++; $display("FAIL lw_be: got %b want 1111", b); end
        if (s != 2) begin n_bad++; $display("FAIL lw_stall: got %0d want 2", s); end
        do_txn(0, 3'b000, 16'h0013, 0, 32'h80FF0000, 1, r, b, w, s);
        n_total++;
        if (r !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", r); end
        do_txn(0, 3'b100, 16'h0013, 0, 32'h80FF0000, 0, r, b, w, s);
        n_total++;
        if (r !== 32'h00000080) begin n_bad++; $display("FAIL lbu_rdata: got %h want 00000080", r); end
        do_txn(0, 3'b001, 16'h0012, 0, 32'h80010000, 2, r, b, w, s);
        n_total++;
        if (r !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_rdata: got %h want ffff8001", r); end
        do_txn(0, 3'b101, 16'h0012, 0, 32'h80010000, 0, r, b, w, s);
        n_total++;
        if (r !== 32'h00008001) begin n_bad++; $display("FAIL lhu_rdata: got %h want 00008001", r); end
    endtask

    task automatic test_stores();
        logic [31:0] r, w; logic [3:0] b; int s;
        do_txn(1, 3'b000, 16'h0006, 32'h12345678, 32'h0, 4, r, b, w, s);
        n_total += 4;
        if (b !== 4'b0100) begin n_bad++; $display("FAIL sb_be: got %b want 0100", b); end
        if (w !== 32'h78787878) begin n_bad++; $display("FAIL sb_wdata: got %h want 78787878", w); end
        if (s != 6) begin n_bad++; $display("FAIL sb_stall: got %0d want 6", s); end
        if (r !== 32'h00008001) begin n_bad++; $display("FAIL sb_rdata_kept: got %h want 00008001", r); end
        do_txn(1, 3'b001, 16'h0002, 32'h0000ABCD, 32'h0, 0, r, b, w, s);
        n_total += 2;
        if (b !== 4'b1100) begin n_bad++; $display("FAIL sh_be: got %b want 1100", b); end
        if (w !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", w); end
    endtask

    task automatic test_illegal();
        do_bad(0, 3'b010, 16'h0002);
        do_bad(0, 3'b011, 16'h0000);
        do_bad(1, 3'b001, 16'h0005);
        do_bad(0, 3'b111, 16'h0004);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, w; logic [3:0] b; int s;
        for (int i = 0; i < 4; i++)
            do_txn(0, 3'b010, 16'(16'h0100 + 4 * i), 0, 32'h1111_0000 + i, 0, r, b, w, s);
    endtask

    task automatic test_random();
        logic [31:0] r, w; logic [3:0] b; int s;
        logic [2:0]  f3; logic [15:0] a; logic we;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & ~16'(size_of(f3) - 1);
            if (is_bad(f3, a)) do_bad(we, f3, a);
            else do_txn(we, f3, a, $urandom, $urandom, $urandom_range(0, 6), r, b, w, s);
        end
    endtask

    task automatic test_timeout();
        int rc; logic e; bit d;
        to_txn(16'h0020, 32'hCAFEF00D, 0, rc, e, d);
        n_total += 2;
        if (!d || e !== 1'b0) begin n_bad++; $display("FAIL to_ok_err: got %b done %0d want 0", e, d); end
        if (core_rdata_to !== 32'hCAFEF00D) begin n_bad++; $display("FAIL to_ok_rdata: got %h want cafef00d", core_rdata_to); end
        // ack on the final WAIT cycle beats the timeout
        to_txn(16'h0024, 32'h0BADF00D, 3, rc, e, d);
        n_total += 2;
        if (!d || e !== 1'b0) begin n_bad++; $display("FAIL to_edge_err: got %b done %0d want 0", e, d); end
        if (core_rdata_to !== 32'h0BADF00D) begin n_bad++; $display("FAIL to_edge_rdata: got %h want 0badf00d", core_rdata_to); end
        to_txn(16'h0028, 32'h12345678, -1, rc, e, d);
        n_total += 4;
        if (!d) begin n_bad++; $display("FAIL to_done: stall never dropped"); end
        if (rc != 4) begin n_bad++; $display("FAIL to_req_cycles: got %0d want 4", rc); end
        if (e !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", e); end
        if (core_rdata_to !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h want 0", core_rdata_to); end
        @(negedge clk);
        n_total += 2;
        if (err_to !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", err_to); end
        if (mem_req_to !== 1'b0) begin n_bad++; $display("FAIL to_req_low: got %b want 0", mem_req_to); end
    endtask

    task automatic test_reset_in_wait();
        bit got;
        got = 0;
        @(posedge clk); #1;
        core_req_to = 1; core_we = 0; core_f3 = 3'b010; core_addr = 16'h0030; ack_to = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = mem_req_to;
        end
        n_total++;
        if (!got) begin n_bad++; $display("FAIL rw_enter: mem_req never rose"); end
        rst = 1; #1;
        n_total++;
        if (stall_to !== 1'b0) begin n_bad++; $display("FAIL rw_stall: got %b want 0", stall_to); end
        @(posedge clk); #1;
        rst = 0; core_req_to = 0; ack_to = 1; mem_rdata = 32'h5555AAAA;
        model_rdata = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total += 3;
            if (mem_req_to !== 1'b0) begin n_bad++; $display("FAIL rw_req: got %b want 0", mem_req_to); end
            if (err_to !== 1'b0) begin n_bad++; $display("FAIL rw_err: got %b want 0", err_to); end
            if (core_rdata_to !== 32'h0) begin n_bad++; $display("FAIL rw_rdata: got %h want 0", core_rdata_to); end
        end
        ack_to = 0;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_illegal();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
